fixed_point_divider: RTL and testbench

Iterative signed fixed-point divider that consumes scalar results from the vector dot-product stage. It computes quotient = dividend / divisor in fixed_point_t format, as needed for ray-plane t = dot(n, p0-o) / dot(n, d) and for vector normalisation. Bit-serial restoring division trades latency for area. Valid/ready handshakes sit on both sides, so it drops between dot-product producers and intersection consumers.

---
 rtl/fixed_point_divider_if.sv | 33 +++
 rtl/fixed_point_divider.sv | 159 +++++++++++++++
 tb/tb_fixed_point_divider.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_divider_if.sv
// ============================================================================
// Module   : fixed_point_divider_if
// Brief    : Operand/result handshake bundle for the fixed-point divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fixed_point_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic             out_overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, in_overflow, out_ready,
        input  in_ready, out_valid, quotient, out_overflow, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, in_overflow, out_ready,
        output in_ready, out_valid, quotient, out_overflow, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/fixed_point_divider.sv
// ============================================================================
// Module   : fixed_point_divider
// Brief    : Bit-serial restoring signed fixed-point divider with saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_divider #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fixed_point_divider_if.slave bus
);

    localparam int NUM_W = WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(NUM_W + 1);

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(NUM_W);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             uovf_q, uovf_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    // Two's-complement negation read as unsigned is exact, including -2^(WIDTH-1)
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    assign w_a_mag    = bus.dividend[WIDTH-1] ? (~bus.dividend + C_ONE) : bus.dividend;
    assign w_b_mag    = bus.divisor[WIDTH-1]  ? (~bus.divisor  + C_ONE) : bus.divisor;
    assign w_div_zero = (bus.divisor == '0);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    assign w_trial    = {rem_q, num_q[NUM_W-1]};
    assign w_diff     = w_trial - {1'b0, den_q};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    // Negative results may reach exactly 2^(WIDTH-1); positive ones may not
    logic             w_hi_nz;
    logic             w_sat;
    logic [WIDTH-1:0] w_signed;
    assign w_hi_nz  = |num_q[NUM_W-1:WIDTH];
    assign w_sat    = sign_q ? (w_hi_nz | (num_q[WIDTH-1] & (|num_q[WIDTH-2:0])))
                             : (w_hi_nz | num_q[WIDTH-1]);
    assign w_signed = sign_q ? (~num_q[WIDTH-1:0] + C_ONE) : num_q[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        den_d      = den_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        uovf_d     = uovf_q;
        dbz_pend_d = dbz_pend_q;
        quot_d     = quot_q;
        ovf_d      = ovf_q;
        dbz_d      = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    num_d      = {w_a_mag, {FRAC_BITS{1'b0}}};
                    den_d      = w_b_mag;
                    rem_d      = '0;
                    sign_d     = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    uovf_d     = bus.in_overflow;
                    dbz_pend_d = w_div_zero;
                    // A zero divisor skips the iterations and only spends the finalise cycle
                    cnt_d      = w_div_zero ? C_LAST : '0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q != C_LAST) begin
                    rem_d = w_rem_next;
                    num_d = {num_q[NUM_W-2:0], w_ge};
                    cnt_d = cnt_q + C_CNT_ONE;
                end else begin
                    state_d = S_DONE;
                    if (dbz_pend_q) begin
                        quot_d = sign_q ? C_NEG_MIN : C_POS_MAX;
                        ovf_d  = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = w_sat ? (sign_q ? C_NEG_MIN : C_POS_MAX) : w_signed;
                        ovf_d  = w_sat | uovf_q;
                        dbz_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            uovf_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            quot_q     <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            uovf_q     <= uovf_d;
            dbz_pend_q <= dbz_pend_d;
            quot_q     <= quot_d;
            ovf_q      <= ovf_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_DONE);
    assign bus.quotient     = quot_q;
    assign bus.out_overflow = ovf_q;
    assign bus.div_by_zero  = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_divider.sv
// ============================================================================
// Module   : tb_fixed_point_divider
// Brief    : Directed scoreboard bench for the fixed-point divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_point_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_point_divider_if #(.WIDTH(32)) dif ();

    fixed_point_divider #(
        .WIDTH    (32),
        .FRAC_BITS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    typedef struct packed {
        logic [31:0] q;
        logic        ovf;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  dif.in_ready,     32'd1);
        chk({tag, "_out_valid"}, dif.out_valid,    32'd0);
        chk({tag, "_quotient"},  dif.quotient,     32'd0);
        chk({tag, "_ovf"},       dif.out_overflow, 32'd0);
        chk({tag, "_dbz"},       dif.div_by_zero,  32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic iovf,
                         input logic [31:0] eq, input logic eovf, input logic edbz);
        int w;
        w = 0;
        while (!dif.in_ready && w < 100) begin
            tick();
            w++;
        end
        dif.dividend    = a;
        dif.divisor     = b;
        dif.in_overflow = iovf;
        dif.in_valid    = 1'b1;
        sb.push_back('{q: eq, ovf: eovf, dbz: edbz});
        tick();
        dif.in_valid    = 1'b0;
    endtask

    task automatic await_result(input string tag, input int elat);
        int lat;
        lat = 0;
        while (!dif.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, elat);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_quotient"},  dif.quotient,     e.q);
            chk({tag, "_ovf"},       dif.out_overflow, e.ovf);
            chk({tag, "_dbz"},       dif.div_by_zero,  e.dbz);
            chk({tag, "_out_valid"}, dif.out_valid,    32'd1);
            chk({tag, "_in_ready"},  dif.in_ready,     32'd0);
        end
    endtask

    task automatic accept(input string tag);
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        chk({tag, "_post_valid"}, dif.out_valid,    32'd0);
        chk({tag, "_post_ready"}, dif.in_ready,     32'd1);
        chk({tag, "_post_ovf"},   dif.out_overflow, 32'd0);
        chk({tag, "_post_dbz"},   dif.div_by_zero,  32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic iovf, input logic [31:0] eq, input logic eovf,
                       input logic edbz, input int elat);
        issue(a, b, iovf, eq, eovf, edbz);
        await_result(tag, elat);
        check_result(tag);
        accept(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   ghosts;

        rst             = 1'b1;
        dif.in_valid    = 1'b0;
        dif.out_ready   = 1'b0;
        dif.dividend    = '0;
        dif.divisor     = '0;
        dif.in_overflow = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        run("div_3_2",      32'h0003_0000, 32'h0002_0000, 1'b0, 32'h0001_8000, 1'b0, 1'b0, 49);
        run("div_7_3",      32'h0007_0000, 32'h0003_0000, 1'b0, 32'h0002_5555, 1'b0, 1'b0, 49);
        run("div_m7_3",     32'hFFF9_0000, 32'h0003_0000, 1'b0, 32'hFFFD_AAAB, 1'b0, 1'b0, 49);
        run("div_m1_4",     32'hFFFF_0000, 32'h0004_0000, 1'b0, 32'hFFFF_C000, 1'b0, 1'b0, 49);
        run("div_0_5",      32'h0000_0000, 32'h0005_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 49);
        run("sat_pos",      32'h7530_0000, 32'h0000_8000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 49);
        run("sat_minneg",   32'h8000_0000, 32'hFFFF_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 49);
        run("exact_minneg", 32'h8000_0000, 32'h0001_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 49);
        run("dbz_pos",      32'h0001_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1);
        run("dbz_neg",      32'hFFFF_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1);
        run("up_ovf",       32'h0004_0000, 32'h0002_0000, 1'b1, 32'h0002_0000, 1'b1, 1'b0, 49);

        // Backpressure: result held while the consumer stalls; new operands ignored
        issue(32'h0005_0000, 32'h0002_0000, 1'b0, 32'h0002_8000, 1'b0, 1'b0);
        await_result("bp", 49);
        e = sb[0];
        dif.dividend = 32'h0001_0000;
        dif.divisor  = 32'h0001_0000;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold_quotient",  dif.quotient,     e.q);
            chk("bp_hold_ovf",       dif.out_overflow, e.ovf);
            chk("bp_hold_in_ready",  dif.in_ready,     32'd0);
            chk("bp_hold_out_valid", dif.out_valid,    32'd1);
        end
        dif.in_valid = 1'b0;
        check_result("bp");
        accept("bp");
        ghosts = 0;
        repeat (60) begin
            tick();
            if (dif.out_valid) ghosts++;
        end
        chk("bp_no_extra_result", ghosts, 32'd0);

        // Asynchronous reset in the middle of an iteration
        issue(32'h0003_0000, 32'h0002_0000, 1'b0, 32'h0001_8000, 1'b0, 1'b0);
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        ghosts = 0;
        repeat (60) begin
            tick();
            if (dif.out_valid) ghosts++;
        end
        chk("midreset_no_stale", ghosts, 32'd0);
        run("after_reset_3_2", 32'h0003_0000, 32'h0002_0000, 1'b0, 32'h0001_8000, 1'b0, 1'b0, 49);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
